// File: rtl/ar4_arb_pkg.sv
// Shared types and helpers for the radix-4 multiplier arbiter.
// Holds the FSM state type, default widths and the round-robin pick function.
package ar4_arb_pkg;

    localparam int DW_DEF   = 16;
    localparam int NREQ_MAX = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    // First set bit of req at or above ptr, wrapping at n.
    function automatic logic [NREQ_MAX-1:0] rr_pick(
        input logic [NREQ_MAX-1:0] req,
        input int                  ptr,
        input int                  n
    );
        logic [NREQ_MAX-1:0] oh;
        logic                found;
        logic [2:0]          idx;
        oh    = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ_MAX; i++) begin
            idx = 3'((ptr + i) % n);
            if (i < n && !found && req[idx]) begin
                oh[idx] = 1'b1;
                found   = 1'b1;
            end
        end
        return oh;
    endfunction

endpackage

// File: rtl/ar4_rr_picker.sv
// Combinational round-robin priority encoder.
// Ports: req (levels), ptr (start index) -> onehot winner, idx (binary), any.
module ar4_rr_picker
    import ar4_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic [PW-1:0]   idx,
    output logic            any
);

    logic [NREQ_MAX-1:0] pick;

    always_comb begin
        pick   = rr_pick(NREQ_MAX'(req), int'(ptr), NREQ);
        onehot = pick[NREQ-1:0];
        any    = |pick;
        idx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick[i]) idx = PW'(i);
        end
    end

endmodule

// File: rtl/ar4_mult_arbiter.sv
// Round-robin arbiter sharing one radix-4 multiplier among NREQ clients.
// Ports: clk/rst, req/req_a/req_x in, gnt/done/result/err/busy out,
// mul_begin/mul_a/mul_x to the multiplier, mul_ready/mul_out from it.
module ar4_mult_arbiter
    import ar4_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_a,
    input  logic [NREQ*DW-1:0] req_x,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic [2*DW-1:0]    result,
    output logic               err,
    output logic               busy,
    output logic               mul_begin,
    output logic [DW-1:0]      mul_a,
    output logic [DW-1:0]      mul_x,
    input  logic               mul_ready,
    input  logic [2*DW-1:0]    mul_out
);

    localparam int PW = $clog2(NREQ);
    localparam int WW = $clog2(TIMEOUT + 1);

    state_t          state, state_nx;
    logic [PW-1:0]   owner;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   ptr_after;
    logic            arm;
    logic [WW-1:0]   wdog;
    logic [NREQ-1:0] pick_oh;
    logic [PW-1:0]   pick_idx;
    logic            pick_any;
    logic            complete;
    logic            expire;

    ar4_rr_picker #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req    (req),
        .ptr    (rr_ptr),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // arm guards against a ready level left over from the previous op
    assign complete  = arm & mul_ready;
    assign expire    = (wdog == WW'(TIMEOUT - 1));
    assign ptr_after = (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        gnt       = '0;
        done      = '0;
        mul_begin = 1'b0;
        busy      = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (pick_any && !rst) begin
                    gnt      = pick_oh;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                mul_begin = 1'b1;
                state_nx  = WAIT;
            end
            WAIT: begin
                if (complete)    state_nx = DONE;
                else if (expire) state_nx = IDLE;
            end
            DONE: begin
                done     = NREQ'(1) << owner;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner  <= '0;
            rr_ptr <= '0;
            arm    <= 1'b0;
            wdog   <= '0;
            result <= '0;
            mul_a  <= '0;
            mul_x  <= '0;
            err    <= 1'b0;
        end else begin
            err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_any) begin
                        owner <= pick_idx;
                        mul_a <= req_a[int'(pick_idx)*DW +: DW];
                        mul_x <= req_x[int'(pick_idx)*DW +: DW];
                    end
                end
                ISSUE: begin
                    arm  <= 1'b0;
                    wdog <= '0;
                end
                WAIT: begin
                    arm <= arm | ~mul_ready;
                    if (complete) begin
                        result <= mul_out;
                    end else if (expire) begin
                        err    <= 1'b1;
                        rr_ptr <= ptr_after;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                DONE: rr_ptr <= ptr_after;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ar4_mult_arbiter.sv
// Directed bench for ar4_mult_arbiter with a behavioural multiplier model.
// Model modes: 0 normal (3-cycle busy), 1 stale ready, 2 hung.
module tb_ar4_mult_arbiter;

    localparam int NREQ    = 4;
    localparam int DW      = 16;
    localparam int TIMEOUT = 64;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [NREQ*DW-1:0]  req_a;
    logic [NREQ*DW-1:0]  req_x;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     done;
    logic [2*DW-1:0]     result;
    logic                err;
    logic                busy;
    logic                mul_begin;
    logic [DW-1:0]       mul_a;
    logic [DW-1:0]       mul_x;
    logic                mul_ready = 1'b1;
    logic [2*DW-1:0]     mul_out;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int excl_bad = 0;
    int mode     = 0;
    int mcnt     = 0;
    logic [2*DW-1:0] prod = '0;

    ar4_mult_arbiter #(
        .NREQ    (NREQ),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_a     (req_a),
        .req_x     (req_x),
        .gnt       (gnt),
        .done      (done),
        .result    (result),
        .err       (err),
        .busy      (busy),
        .mul_begin (mul_begin),
        .mul_a     (mul_a),
        .mul_x     (mul_x),
        .mul_ready (mul_ready),
        .mul_out   (mul_out)
    );

    always #2 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mul_begin) begin
            prod      <= $signed(mul_a) * $signed(mul_x);
            mcnt      <= (mode == 1) ? 5 : 3;
            mul_ready <= (mode == 1);
        end else if (mcnt != 0) begin
            mcnt      <= mcnt - 1;
            mul_ready <= 1'b0;
        end else if (mode != 2) begin
            mul_ready <= 1'b1;
        end
    end

    assign mul_out = prod;

    always @(negedge clk) begin
        if ((done != 0 && err) || (gnt != 0 && busy)) excl_bad++;
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_op(input int i, input int a, input int x);
        req_a[i*DW +: DW] = DW'(a);
        req_x[i*DW +: DW] = DW'(x);
    endtask

    task automatic drive_slot();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(output logic [NREQ-1:0] g, output int at);
        logic seen;
        seen = 1'b0;
        g    = '0;
        at   = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (gnt != 0) begin
                seen = 1'b1;
                g    = gnt;
                at   = cyc;
            end
        end
        check("gnt_bound", longint'(seen), 1);
    endtask

    task automatic wait_evt(output logic [NREQ-1:0] d, output logic e,
                            output int at);
        logic seen;
        seen = 1'b0;
        d    = '0;
        e    = 1'b0;
        at   = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (done != 0 || err) begin
                seen = 1'b1;
                d    = done;
                e    = err;
                at   = cyc;
            end
        end
        check("evt_bound", longint'(seen), 1);
    endtask

    logic [NREQ-1:0] g;
    logic [NREQ-1:0] d;
    logic            e;
    int              tg;
    int              td;
    int              quiet;
    logic [NREQ-1:0] exp_d [5];
    longint          exp_r [5];

    initial begin
        rst   = 1'b1;
        req   = '0;
        req_a = '0;
        req_x = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy",   busy,      0);
        check("rst_gnt",    gnt,       0);
        check("rst_done",   done,      0);
        check("rst_err",    err,       0);
        check("rst_begin",  mul_begin, 0);
        check("rst_result", result,    0);

        // single op
        drive_slot();
        set_op(0, -17, 9);
        req = 4'b0001;
        wait_gnt(g, tg);
        check("t1_gnt", g, 4'b0001);
        drive_slot();
        req = '0;
        @(negedge clk);
        check("t1_gnt_1cyc", gnt, 0);
        check("t1_begin", mul_begin, 1);
        check("t1_busy", busy, 1);
        check("t1_mul_a", $signed(mul_a), -17);
        check("t1_mul_x", $signed(mul_x), 9);
        wait_evt(d, e, td);
        check("t1_done", d, 4'b0001);
        check("t1_err", e, 0);
        check("t1_result", $signed(result), -153);
        check("t1_latency", td - tg, 7);
        @(negedge clk);
        check("t1_idle", busy, 0);
        check("t1_done_1cyc", done, 0);

        // contention from a fresh pointer
        drive_slot();
        rst = 1'b1;
        drive_slot();
        rst = 1'b0;
        set_op(0, 3, 4);
        set_op(1, -5, 6);
        set_op(2, 7, -8);
        set_op(3, -9, -10);
        exp_d = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_r = '{12, -30, -56, 90, 12};
        req = 4'b1111;
        wait_gnt(g, tg);
        check("t2_gnt0", g, 4'b0001);
        for (int k = 0; k < 5; k++) begin
            wait_evt(d, e, td);
            check("t2_done", d, exp_d[k]);
            check("t2_result", $signed(result), exp_r[k]);
            if (k < 4) begin
                wait_gnt(g, tg);
                check("t2_gnt", g, exp_d[k+1]);
                check("t2_b2b", tg - td, 1);
            end
        end
        drive_slot();
        req = '0;

        // serve 3 so the pointer wraps to 0
        set_op(3, 2, 3);
        req = 4'b1000;
        wait_gnt(g, tg);
        check("t3_gnt3", g, 4'b1000);
        drive_slot();
        req = '0;
        wait_evt(d, e, td);
        check("t3_result6", $signed(result), 6);
        drive_slot();
        req = 4'b1001;
        wait_gnt(g, tg);
        check("t3_wrap_gnt0", g, 4'b0001);
        wait_evt(d, e, td);
        check("t3_done0", d, 4'b0001);
        wait_gnt(g, tg);
        check("t3_then_gnt3", g, 4'b1000);
        drive_slot();
        req = '0;
        wait_evt(d, e, td);
        check("t3_done3", d, 4'b1000);

        // stale ready from the previous op
        drive_slot();
        mode = 1;
        set_op(2, 7, -8);
        req = 4'b0100;
        wait_gnt(g, tg);
        drive_slot();
        req = '0;
        wait_evt(d, e, td);
        check("t4_done", d, 4'b0100);
        check("t4_latency", td - tg, 9);
        check("t4_result", $signed(result), -56);
        mode = 0;

        // hung multiplier
        drive_slot();
        mode = 2;
        set_op(1, 1, 1);
        req = 4'b0010;
        wait_gnt(g, tg);
        drive_slot();
        req = '0;
        wait_evt(d, e, td);
        check("t5_err", e, 1);
        check("t5_no_done", d, 0);
        check("t5_err_time", td - tg, TIMEOUT + 2);
        @(negedge clk);
        check("t5_err_1cyc", err, 0);
        drive_slot();
        mode = 0;
        set_op(1, -9, -10);
        req = 4'b0010;
        wait_gnt(g, tg);
        check("t5_regnt", g, 4'b0010);
        drive_slot();
        req = '0;
        wait_evt(d, e, td);
        check("t5_done", d, 4'b0010);
        check("t5_result", $signed(result), 90);

        // reset mid-WAIT
        drive_slot();
        set_op(0, 100, -2);
        req = 4'b0001;
        wait_gnt(g, tg);
        drive_slot();
        req = '0;
        repeat (3) @(negedge clk);
        check("t6_in_wait", busy, 1);
        drive_slot();
        rst = 1'b1;
        drive_slot();
        rst = 1'b0;
        @(negedge clk);
        check("t6_busy", busy, 0);
        check("t6_result", result, 0);
        check("t6_mul_a", mul_a, 0);
        check("t6_mul_x", mul_x, 0);
        check("t6_begin", mul_begin, 0);
        quiet = 0;
        repeat (20) begin
            @(negedge clk);
            if (done != 0 || err) quiet++;
        end
        check("t6_quiet", quiet, 0);
        drive_slot();
        req = 4'b0001;
        wait_gnt(g, tg);
        drive_slot();
        req = '0;
        wait_evt(d, e, td);
        check("t6_done", d, 4'b0001);
        check("t6_result2", $signed(result), -200);

        check("exclusive", excl_bad, 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
